// File: rtl/reg_responder.sv
// Register-file responder with a req/ack handshake, programmable wait states,
// a saturating change counter, an ID word and error signalling on unmapped addresses.
module reg_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h5652_4547
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        change
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The wait counter counts down from WAIT_CYCLES-1, so WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [3:0]  wait_cnt_r, wait_cnt_s;
  logic        wr_r;
  logic [2:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] regs_r [4];
  logic [15:0] chg_cnt_r;
  logic        ack_r, err_r, change_r;
  logic [31:0] rdata_r;

  logic        access_s;
  logic [31:0] old_val_s;
  logic        reg_we_s;
  logic        alter_s;
  logic        cnt_clr_s;
  logic        err_s;
  logic [31:0] rd_val_s;

  // Handshake sequencing: next state and wait-counter update.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 32'd0) begin
            state_s = ACK;
          end else begin
            state_s    = WAIT;
            wait_cnt_s = WAIT_LAST;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_s = ACK;
        end else begin
          wait_cnt_s = wait_cnt_r - 4'd1;
        end
      end
      ACK: begin
        state_s = DONE;
      end
      DONE: begin
        if (!req) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s    = IDLE;
        wait_cnt_s = 4'd0;
      end
    endcase
  end

  // Access decode for the committing cycle; a write returns its post-write value.
  always_comb begin
    access_s  = (state_r == ACK);
    old_val_s = regs_r[addr_r[1:0]];
    reg_we_s  = access_s && wr_r && (addr_r[2] == 1'b0);
    alter_s   = reg_we_s && (wdata_r != old_val_s);
    cnt_clr_s = access_s && wr_r && (addr_r == 3'd4);
    err_s     = access_s && (addr_r[2:1] == 2'b11);
    case (addr_r)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        if (wr_r) begin
          rd_val_s = wdata_r;
        end else begin
          rd_val_s = old_val_s;
        end
      end
      3'd4: begin
        if (wr_r) begin
          rd_val_s = 32'h0;
        end else begin
          rd_val_s = {16'h0, chg_cnt_r};
        end
      end
      3'd5:    rd_val_s = ID_VALUE;
      default: rd_val_s = 32'h0;
    endcase
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
      wr_r       <= 1'b0;
      addr_r     <= 3'd0;
      wdata_r    <= 32'h0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if ((state_r == IDLE) && req) begin
        wr_r    <= wr;
        addr_r  <= addr;
        wdata_r <= wdata;
      end else begin
        wr_r    <= wr_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  // Register storage and the saturating change counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_r[0] <= 32'h0000_0000;
      regs_r[1] <= 32'h0000_0000;
      regs_r[2] <= 32'h1234_5678;
      regs_r[3] <= 32'hFFFF_FFFF;
      chg_cnt_r <= 16'h0;
    end else begin
      if (reg_we_s) begin
        regs_r[addr_r[1:0]] <= wdata_r;
      end
      if (cnt_clr_s) begin
        chg_cnt_r <= 16'h0;
      end else if (alter_s && (chg_cnt_r != 16'hFFFF)) begin
        chg_cnt_r <= chg_cnt_r + 16'd1;
      end else begin
        chg_cnt_r <= chg_cnt_r;
      end
    end
  end

  // Registered completion outputs; rdata is forced to zero outside the ack cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      change_r <= 1'b0;
      rdata_r  <= 32'h0;
    end else begin
      ack_r    <= access_s;
      err_r    <= err_s;
      change_r <= alter_s;
      rdata_r  <= access_s ? rd_val_s : 32'h0;
    end
  end

  assign ack    = ack_r;
  assign err    = err_r;
  assign change = change_r;
  assign rdata  = rdata_r;

endmodule

// File: doc/reg_responder.md
REG_RESPONDER -- requirements
Module: reg_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states inserted before ack; legal range 0..15.
REQ-002 SHALL have parameter ID_VALUE, default 32'h5652_4547, giving the constant returned at address 5.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, width 1, the sole clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset_n, input, width 1, the asynchronous active-low reset.
REQ-006 SHALL have port req, input, width 1, the initiator request level.
REQ-007 SHALL have port wr, input, width 1: 1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr, input, width 3, the register address; sampled with req.
REQ-009 SHALL have port wdata, input, width 32, the write data; sampled with req.
REQ-010 SHALL have port ack, output, width 1, a one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, width 32, the read data, valid only while ack=1 and 0 otherwise.
REQ-012 SHALL have port err, output, width 1, pulsed with ack for any access to address 6 or 7.
REQ-013 SHALL have port change, output, width 1, a one-cycle pulse when a write alters a stored value.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK, DONE.
REQ-015 SHALL, in IDLE with req=1 at an edge, capture wr/addr/wdata and go to WAIT, or go directly to ACK when WAIT_CYCLES=0.
REQ-016 SHALL hold WAIT for exactly WAIT_CYCLES cycles using a 4-bit counter, then go to ACK.
REQ-017 SHALL drive ack=1 for exactly one cycle in ACK, then go to DONE; latency from req-sampled edge to ack-high edge is WAIT_CYCLES+1.
REQ-018 SHALL stay in DONE until req=0 is sampled, then return to IDLE; a held req SHALL never produce a second ack.
REQ-019 SHALL ignore changes to wr/addr/wdata after capture.
REQ-020 SHALL treat addresses 0..3 as 32-bit R/W registers with reset values 32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF.
REQ-021 SHALL treat address 4 as a read-only change counter, 16 bits, zero-extended on read; a write of any data clears it to 0 and does not pulse change.
REQ-022 SHALL return ID_VALUE on a read of address 5; writes to address 5 are ignored without err.
REQ-023 SHALL, for address 6 or 7, return rdata=0, ignore writes, and pulse err with ack.
REQ-024 SHALL commit a register write in the same edge that raises ack; a read in the same cycle as a commit returns the post-write value.
REQ-025 SHALL pulse change with ack only when the written register's new value differs from its old value.
REQ-026 SHALL increment the counter on each change pulse, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, while reset_n=0: set state to IDLE, set ack, err, change and rdata to 0, set registers to the REQ-020 values, set the counter and wait counter to 0.
REQ-028 SHALL, on reset mid-transaction, abandon the access with no commit and no ack; the initiator reissues it.
REQ-029 SHALL be able to sample req on the first rising edge after reset_n deasserts.

Verification
REQ-030 SHALL verify reset values: after reset, read 0..5 -> 0, 0, 12345678, FFFFFFFF, 0, 56524547; ack 3 cycles after each req (WAIT_CYCLES=2).
REQ-031 SHALL verify writes and change pulses: write 0 with A5A5A5A5 -> change=1 and counter=1; write the same value again -> change=0 and counter=1; read 0 -> A5A5A5A5.
REQ-032 SHALL verify the handshake: hold req high 20 cycles -> exactly one ack; drop and reraise req -> second ack after WAIT_CYCLES+1.
REQ-033 SHALL verify bad addresses: read 6 -> rdata=0, err=1; write 7 -> err=1, no state change; write 5 -> err=0, ID unchanged.
REQ-034 SHALL verify reset mid-write: assert reset_n=0 during WAIT of a write to 2 with 0 -> no ack, and register 2 reads 12345678 after reset.
REQ-035 SHALL verify WAIT_CYCLES=0: ack on the edge after the req-sampled edge; 65537 altering writes -> counter reads 0000FFFF.
